// File: rtl/proc_ctrl_fsm.sv
// Control-unit FSM for the 16-bit datapath: decodes IR and sequences bus drivers and write enables over T0..T3.
// Optional macro PROC_MVNZ_EN enables conditional move (op 101); without it op 101 is a NOP and GNZ is ignored.
module proc_ctrl_fsm #(
    parameter int N    = 16,
    parameter int NREG = 8
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            run_i,
    input  logic [N-1:0]    ir_i,
    input  logic            gnz_i,
    output logic            irin_o,
    output logic [NREG-1:0] rin_o,
    output logic [NREG-1:0] rout_o,
    output logic            gout_o,
    output logic            dinout_o,
    output logic            ain_o,
    output logic            gin_o,
    output logic [1:0]      aluop_o,
    output logic            done_o
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

    state_t     state_q, state_d;
    logic [2:0] op;
    logic [2:0] x_sel;
    logic [2:0] y_sel;
    logic       is_alu;

    assign op     = ir_i[N-1 -: 3];
    assign x_sel  = ir_i[N-4 -: 3];
    assign y_sel  = ir_i[N-7 -: 3];
    assign is_alu = (op == 3'b010) || (op == 3'b011) || (op == 3'b100);

`ifdef PROC_MVNZ_EN
    logic unused_ir;
    assign unused_ir = ^ir_i[N-10:0];
`else
    logic unused_ir;
    assign unused_ir = ^{ir_i[N-10:0], gnz_i};
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = T0;
        irin_o   = 1'b0;
        rin_o    = '0;
        rout_o   = '0;
        gout_o   = 1'b0;
        dinout_o = 1'b0;
        ain_o    = 1'b0;
        gin_o    = 1'b0;
        aluop_o  = 2'b00;
        done_o   = 1'b0;
        // Reset overrides everything so an aborted instruction leaves no trace on the outputs.
        if (!reset_i) begin
            case (state_q)
                T0: begin
                    irin_o  = run_i;
                    state_d = run_i ? T1 : T0;
                end
                T1: begin
                    case (op)
                        3'b000: begin
                            rout_o = ONE_HOT0 << y_sel;
                            rin_o  = ONE_HOT0 << x_sel;
                            done_o = 1'b1;
                        end
                        3'b001: begin
                            dinout_o = 1'b1;
                            rin_o    = ONE_HOT0 << x_sel;
                            done_o   = 1'b1;
                        end
                        3'b010, 3'b011, 3'b100: begin
                            rout_o  = ONE_HOT0 << x_sel;
                            ain_o   = 1'b1;
                            state_d = T2;
                        end
`ifdef PROC_MVNZ_EN
                        3'b101: begin
                            if (gnz_i) begin
                                rout_o = ONE_HOT0 << y_sel;
                                rin_o  = ONE_HOT0 << x_sel;
                            end
                            done_o = 1'b1;
                        end
`endif
                        default: done_o = 1'b1;
                    endcase
                end
                T2: begin
                    if (is_alu) begin
                        rout_o  = ONE_HOT0 << y_sel;
                        gin_o   = 1'b1;
                        aluop_o = op[2] ? 2'b10 : {1'b0, op[0]};
                        state_d = T3;
                    end
                end
                T3: begin
                    if (is_alu) begin
                        gout_o = 1'b1;
                        rin_o  = ONE_HOT0 << x_sel;
                        done_o = 1'b1;
                    end
                end
                default: state_d = T0;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm: per-cycle expected output vectors are queued as stimulus is driven.
module tb_proc_ctrl_fsm;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       gout;
        logic       dinout;
        logic       ain;
        logic       gin;
        logic [1:0] aluop;
        logic       done;
    } out_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        run_i = 1'b0;
    logic [15:0] ir_i = '0;
    logic        gnz_i = 1'b0;
    logic        irin_o, gout_o, dinout_o, ain_o, gin_o, done_o;
    logic [7:0]  rin_o, rout_o;
    logic [1:0]  aluop_o;

    int   errors = 0;
    int   checks = 0;
    int   bus_viol = 0;
    int   done_cnt = 0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    proc_ctrl_fsm dut (
        .clock_i (clk),
        .reset_i (reset_i),
        .run_i   (run_i),
        .ir_i    (ir_i),
        .gnz_i   (gnz_i),
        .irin_o  (irin_o),
        .rin_o   (rin_o),
        .rout_o  (rout_o),
        .gout_o  (gout_o),
        .dinout_o(dinout_o),
        .ain_o   (ain_o),
        .gin_o   (gin_o),
        .aluop_o (aluop_o),
        .done_o  (done_o)
    );

    always @(negedge clk) begin
        if (($countones(rout_o) + gout_o + dinout_o) > 1 || $countones(rin_o) > 1)
            bus_viol++;
        if (done_o === 1'b1)
            done_cnt++;
    end

    function automatic out_t mk(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                input logic gout, input logic din, input logic ain, input logic gin,
                                input logic [1:0] alu, input logic done);
        return '{irin, rin, rout, gout, din, ain, gin, alu, done};
    endfunction

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
        return {op, x, y, 7'h55};
    endfunction

    task automatic step(input string tag, input logic rst, input logic run,
                        input logic [15:0] ir, input logic gnz);
        out_t act, e;
        reset_i = rst;
        run_i   = run;
        ir_i    = ir;
        gnz_i   = gnz;
        @(negedge clk);
        act = '{irin_o, rin_o, rout_o, gout_o, dinout_o, ain_o, gin_o, aluop_o, done_o};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, actual %h", tag, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: actual %h required %h", tag, act, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [15:0] nop;
        nop = ins(3'b110, 3'd0, 3'd0);
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("reset_c0", 1, 1, nop, 1);
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("reset_c1", 1, 1, nop, 1);
        exp_q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("reset_first_irin", 0, 1, nop, 0);
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1));
        step("nop_t1", 0, 0, nop, 0);
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("idle_t0", 0, 0, nop, 0);
    endtask

    task automatic test_mv;
        logic [15:0] i;
        i = ins(3'b000, 3'd2, 3'd5);
        exp_q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("mv_t0", 0, 1, i, 0);
        exp_q.push_back(mk(0, 8'h04, 8'h20, 0, 0, 0, 0, 2'b00, 1));
        step("mv_t1", 0, 0, i, 0);
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("mv_back_t0", 0, 0, i, 0);
    endtask

    task automatic run_alu(input string tag, input logic [2:0] op, input logic [2:0] x,
                           input logic [2:0] y, input logic [1:0] alu);
        logic [15:0] i;
        logic [7:0]  xo, yo;
        i  = ins(op, x, y);
        xo = 8'h01 << x;
        yo = 8'h01 << y;
        exp_q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step({tag, "_t0"}, 0, 1, i, 1);
        exp_q.push_back(mk(0, 8'h00, xo, 0, 0, 1, 0, 2'b00, 0));
        step({tag, "_t1"}, 0, 1, i, 1);
        exp_q.push_back(mk(0, 8'h00, yo, 0, 0, 0, 1, alu, 0));
        step({tag, "_t2"}, 0, 1, i, 0);
        exp_q.push_back(mk(0, xo, 8'h00, 1, 0, 0, 0, 2'b00, 1));
        step({tag, "_t3"}, 0, 0, i, 0);
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step({tag, "_idle"}, 0, 0, i, 0);
    endtask

    task automatic test_alu;
        int d0;
        d0 = done_cnt;
        run_alu("sub", 3'b011, 3'd1, 3'd3, 2'b01);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL sub_done_once: actual %0d required 1", done_cnt - d0);
        end
        run_alu("add_xy", 3'b010, 3'd6, 3'd6, 2'b00);
        run_alu("and", 3'b100, 3'd0, 3'd7, 2'b10);
    endtask

    task automatic test_mvnz;
        logic [15:0] i;
        i = ins(3'b101, 3'd0, 3'd7);
        exp_q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("mvnz0_t0", 0, 1, i, 0);
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1));
        step("mvnz0_t1", 0, 0, i, 0);
        exp_q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("mvnz1_t0", 0, 1, i, 1);
`ifdef PROC_MVNZ_EN
        exp_q.push_back(mk(0, 8'h01, 8'h80, 0, 0, 0, 0, 2'b00, 1));
`else
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1));
`endif
        step("mvnz1_t1", 0, 0, i, 1);
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("mvnz_idle", 0, 0, i, 1);
    endtask

    task automatic test_reset_abort;
        logic [15:0] a, m;
        int d0;
        a = ins(3'b010, 3'd3, 3'd4);
        m = ins(3'b001, 3'd4, 3'd0);
        exp_q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("abort_t0", 0, 1, a, 0);
        exp_q.push_back(mk(0, 8'h00, 8'h08, 0, 0, 1, 0, 2'b00, 0));
        step("abort_t1", 0, 0, a, 0);
        d0 = done_cnt;
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("abort_t2_reset", 1, 0, a, 0);
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("abort_after", 0, 0, a, 0);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL abort_no_done: actual %0d required %0d", done_cnt, d0);
        end
        exp_q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("mvi_after_abort_t0", 0, 1, m, 0);
        exp_q.push_back(mk(0, 8'h10, 8'h00, 0, 1, 0, 0, 2'b00, 1));
        step("mvi_after_abort_t1", 0, 0, m, 0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] m;
        int d0;
        m  = ins(3'b001, 3'd3, 3'd1);
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
            step("b2b_t0", 0, 1, m, 0);
            exp_q.push_back(mk(0, 8'h08, 8'h00, 0, 1, 0, 0, 2'b00, 1));
            step("b2b_t1", 0, 1, m, 0);
        end
        checks++;
        if (done_cnt - d0 !== 3) begin
            errors++;
            $display("FAIL b2b_done_count: actual %0d required 3", done_cnt - d0);
        end
        exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        step("b2b_idle", 0, 0, m, 0);
    endtask

    initial begin
        test_reset();
        test_mv();
        test_alu();
        test_mvnz();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (bus_viol !== 0) begin
            errors++;
            $display("FAIL bus_rule: actual %0d violations required 0", bus_viol);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d left required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
